btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
- Controls all front-panel buttons (spin, bet-up, bet-down, cash-out) through one shared debounce resource.
- Generates a single sample tick, synchronises and debounces every raw button, and turns debounced presses and held-button auto-repeats into events.
- Arbitrates those events round-robin onto one valid/ready channel consumed by the game FSM.
- All logic runs on clk; no derived clocks.

Parameters:
- NUM_BTN, 4, number of buttons (legal range 2..4; button i maps to evt_id i).
- TICK_DIV, 100000, clk cycles per sample tick.
- STABLE_CNT, 4, consecutive ticks of a differing level required before btn_db changes.
- HOLD_TICKS, 50, ticks a button must stay held after its press before the first auto-repeat event.
- REPEAT_TICKS, 10, ticks between subsequent auto-repeat events.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_raw  in  NUM_BTN  asynchronous raw button levels, active-high
- btn_db  out  NUM_BTN  debounced levels
- evt_valid  out  1  event offered
- evt_ready  in  1  consumer accepts the event when evt_valid=1
- evt_id  out  2  button index of the offered event
- evt_repeat  out  1  0 = press event, 1 = auto-repeat event
- ovr_clr  in  1  clears overrun
- overrun  out  1  sticky: an event was lost

Behaviour:
- Reset: on rst=1 at a clk edge, all of the following clear: tick counter, synchronisers, stable counters, hold counters, pending and pending_rep, btn_db, evt_valid, evt_id, evt_repeat, overrun. The round-robin pointer is set to NUM_BTN-1. rst asserted during an offer drops that event.
- Tick: the counter runs 0..TICK_DIV-1 and wraps. tick=1 for exactly one clk when counter==TICK_DIV-1.
- Sync: each btn_raw bit passes through two flops (sync[i]).
- Debounce, on tick only:
  - If sync[i]!=btn_db[i], stab[i] increments.
  - When stab[i] reaches STABLE_CNT-1 and the level still differs, btn_db[i] flips and stab[i] clears.
  - If sync[i]==btn_db[i], stab[i] clears.
- Press event: a btn_db[i] 0->1 transition sets pending[i]=1 with pending_rep[i]=0, and clears hold[i].
- Auto-repeat, on tick while btn_db[i]=1:
  - hold[i] increments.
  - A repeat event fires when hold[i]==HOLD_TICKS, then every REPEAT_TICKS ticks after that.
  - A repeat sets pending[i]=1 with pending_rep[i]=1; if pending[i] was already 1, pending_rep[i] keeps its old value.
  - hold[i] saturates and wraps only within the repeat interval.
  - btn_db[i]=0 clears hold[i].
- Overrun: a new event for button i while pending[i]=1 (and not being captured in the same cycle) sets overrun=1. The events merge into one pending entry. overrun stays set until ovr_clr=1 or rst=1; on the same cycle as ovr_clr, a new overrun wins.
- Arbiter FSM:
  - IDLE:
    - If any pending bit is set, search from ptr+1 modulo NUM_BTN upward and capture the first set index k.
    - On capture: evt_id<=k, evt_repeat<=pending_rep[k], evt_valid<=1, pending[k]<=0; go to OFFER.
  - OFFER:
    - evt_id and evt_repeat are held stable while evt_valid=1 and evt_ready=0.
    - On evt_valid&&evt_ready: ptr<=evt_id, evt_valid<=0, go to IDLE.
  - Throughput: at most one event per 2 clk. evt_valid rises 1 clk after pending is set.
- Simultaneous events:
  - A new event for k in the capture cycle leaves pending[k]=1 (set wins) with no overrun.
  - A new event for the button currently in OFFER sets pending normally.
- btn_db and the events have no combinational path from any input.

Test Plan:
Sim parameters: TICK_DIV=4, STABLE_CNT=3, HOLD_TICKS=5, REPEAT_TICKS=2, evt_ready=1 unless stated.
1. Tick spacing: free run 40 clk -> tick pulses exactly every 4 clk, each 1 clk wide.
2. Bounce: btn_raw[0] toggles every tick for 6 ticks, then stays high -> btn_db[0] rises once, on the 3rd stable tick; exactly one event (evt_id=0, evt_repeat=0); overrun=0.
3. Round-robin order:
   - Buttons 0 and 2 debounce in the same tick -> id 0 accepted, then id 2, 2 clk apart.
   - Then buttons 0 and 1 together -> id 0, then id 1.
4. Backpressure and overrun with evt_ready=0:
   - Press button 1 -> id 1 is offered and held stable.
   - Release and press button 1 again -> pending, overrun=0.
   - Third press -> overrun=1.
   - Set evt_ready=1 -> exactly two events delivered.
   - ovr_clr -> overrun=0.
5. Auto-repeat: hold btn_raw[3] for 12 ticks after debounce -> press event, then repeat events (evt_repeat=1) at +5, +7, +9 and +11 ticks; release -> no further events.
6. Reset mid-offer: evt_ready=0 with an event in OFFER and another pending; pulse rst -> next clk evt_valid=0, btn_db=0, overrun=0, no event after reset until a new press.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// Front-panel button controller: one shared sample tick, per-button sync and
// debounce, press/auto-repeat event generation, round-robin valid/ready channel.
module btn_event_ctrl #(
  parameter int NUM_BTN      = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_CNT   = 4,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_db,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_id,
  output logic               evt_repeat,
  input  logic               ovr_clr,
  output logic               overrun
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int HW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);
  localparam int PW = $clog2(NUM_BTN);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_TICKS + REPEAT_TICKS - 1);
  localparam logic [HW-1:0] HOLD_BASE = HW'(HOLD_TICKS);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_OFFER = 1'b1} state_e;

  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic                       tick_s;
  logic [NUM_BTN-1:0]         sync1_q, sync2_q;
  logic [NUM_BTN-1:0]         db_q, db_d;
  logic [NUM_BTN-1:0][SW-1:0] stab_q, stab_d;
  logic [NUM_BTN-1:0][HW-1:0] hold_q, hold_d, hold_nx_s;
  logic [NUM_BTN-1:0]         hold_hit_s, press_s, rep_s, ev_s, cap_s;
  logic [NUM_BTN-1:0]         pend_q, pend_d, prep_q, prep_d;
  logic                       ovr_q, ovr_d, ovr_set_s;
  state_e                     state_q, state_d;
  logic [PW-1:0]              ptr_q, ptr_d, k_s, k_hi_s, k_lo_s;
  logic                       found_hi_s, any_s;
  logic                       valid_q, valid_d, rep_q, rep_d;
  logic [1:0]                 id_q, id_d;

  assign tick_s = (tcnt_q == TICK_LAST);
  assign tcnt_d = tick_s ? '0 : tcnt_q + TW'(1);
  assign ev_s   = press_s | rep_s;
  assign any_s  = |pend_q;

  // Datapath registers: tick counter, synchronisers, debounce, pending, overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      stab_q  <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
      prep_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      prep_q  <= prep_d;
      ovr_q   <= ovr_d;
    end
  end

  // Hold counter advance: wraps inside the repeat interval once HOLD_TICKS is reached.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_hit_s[i] = (hold_q[i] == HOLD_PRE) || (hold_q[i] == HOLD_TOP);
      if (hold_q[i] == HOLD_TOP) begin
        hold_nx_s[i] = HOLD_BASE;
      end else begin
        hold_nx_s[i] = hold_q[i] + HW'(1);
      end
    end
  end

  // Per-button debounce and press/repeat event detection, evaluated on tick.
  always_comb begin
    db_d    = db_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    press_s = '0;
    rep_s   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (tick_s) begin
        if (sync2_q[i] == db_q[i] || stab_q[i] == STAB_LAST) begin
          stab_d[i] = '0;
        end else begin
          stab_d[i] = stab_q[i] + SW'(1);
        end
        if (sync2_q[i] != db_q[i] && stab_q[i] == STAB_LAST) begin
          db_d[i]    = ~db_q[i];
          hold_d[i]  = '0;
          press_s[i] = ~db_q[i];
        end else if (db_q[i]) begin
          hold_d[i] = hold_nx_s[i];
          rep_s[i]  = hold_hit_s[i];
        end else begin
          hold_d[i] = '0;
        end
      end else begin
        db_d[i] = db_q[i];
      end
    end
  end

  // Pending set/merge/clear; a capture of the same button in this cycle is not an overrun.
  always_comb begin
    pend_d    = pend_q;
    prep_d    = prep_q;
    ovr_set_s = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (ev_s[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !cap_s[i]) begin
          ovr_set_s = 1'b1;
        end else begin
          prep_d[i] = rep_s[i];
        end
      end else if (cap_s[i]) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Round-robin search: lowest pending index above ptr, else lowest overall.
  always_comb begin
    found_hi_s = 1'b0;
    k_hi_s     = '0;
    k_lo_s     = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        k_lo_s = PW'(i);
        if (i > int'(ptr_q)) begin
          found_hi_s = 1'b1;
          k_hi_s     = PW'(i);
        end
      end
    end
    k_s = found_hi_s ? k_hi_s : k_lo_s;
  end

  // Arbiter state and registered channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      id_q    <= 2'd0;
      rep_q   <= 1'b0;
      ptr_q   <= PW'(NUM_BTN - 1);
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      rep_q   <= rep_d;
      ptr_q   <= ptr_d;
    end
  end

  // Arbiter next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = any_s ? S_OFFER : S_IDLE;
      S_OFFER: state_d = evt_ready ? S_IDLE : S_OFFER;
      default: state_d = S_IDLE;
    endcase
  end

  // Arbiter outputs: capture into the offer registers, release on handshake.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    rep_d   = rep_q;
    ptr_d   = ptr_q;
    cap_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (any_s) begin
          valid_d    = 1'b1;
          id_d       = 2'(k_s);
          rep_d      = prep_q[k_s];
          cap_s[k_s] = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      S_OFFER: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          ptr_d   = PW'(id_q);
        end else begin
          valid_d = 1'b1;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  assign btn_db     = db_q;
  assign evt_valid  = valid_q;
  assign evt_id     = id_q;
  assign evt_repeat = rep_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: behavioural reference model pushes expected events
// into a scoreboard queue; a negedge monitor pops and compares on each handshake.
module tb_btn_event_ctrl;
  localparam int NB = 4, TD = 4, SC = 3, HT = 5, RT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_db;
  logic evt_valid, evt_repeat, overrun;
  logic evt_ready = 1'b1;
  logic ovr_clr = 1'b0;
  logic [1:0] evt_id;

  btn_event_ctrl #(.NUM_BTN(NB), .TICK_DIV(TD), .STABLE_CNT(SC),
                   .HOLD_TICKS(HT), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_db(btn_db),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_repeat(evt_repeat), .ovr_clr(ovr_clr), .overrun(overrun));

  always #5 clk = ~clk;

  typedef struct { int id; bit rep; } evt_t;
  evt_t exp_q[$];
  int   got_id[$];
  int   got_rep[$];
  int   got_cyc[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;

  // Reference model state: held counts run unbounded, repeats found by arithmetic.
  int m_cnt = 0;
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_pend = '0, m_prep = '0;
  int m_diff[NB];
  int m_held[NB];
  bit m_busy = 1'b0, m_ovr = 1'b0;
  int m_offer = 0, m_ptr = NB - 1;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0; m_prep = '0;
    m_busy = 1'b0; m_ovr = 1'b0; m_offer = 0; m_ptr = NB - 1;
    for (int i = 0; i < NB; i++) begin m_diff[i] = 0; m_held[i] = 0; end
    exp_q.delete();
  endtask

  task automatic model_step();
    bit [NB-1:0] ev, evrep;
    bit ovset;
    int cap;
    evt_t e;
    if (rst) begin model_reset(); return; end
    ev = '0; evrep = '0; cap = -1; ovset = 1'b0;
    if (m_cnt == TD - 1) begin
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] != m_db[i]) m_diff[i]++; else m_diff[i] = 0;
        if (m_diff[i] == SC) begin
          m_db[i] = ~m_db[i]; m_diff[i] = 0; m_held[i] = 0;
          ev[i] = m_db[i];
        end else if (m_db[i]) begin
          m_held[i]++;
          if (m_held[i] >= HT && (m_held[i] - HT) % RT == 0) begin ev[i] = 1'b1; evrep[i] = 1'b1; end
        end else begin
          m_held[i] = 0;
        end
      end
    end
    if (!m_busy) begin
      for (int o = 1; o <= NB; o++) begin
        int j = (m_ptr + o) % NB;
        if (cap < 0 && m_pend[j]) cap = j;
      end
      if (cap >= 0) begin
        e.id = cap; e.rep = m_prep[cap]; exp_q.push_back(e);
        m_busy = 1'b1; m_offer = cap;
      end
    end else if (evt_ready) begin
      m_ptr = m_offer; m_busy = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      if (ev[i]) begin
        if (m_pend[i] && i != cap) ovset = 1'b1; else m_prep[i] = evrep[i];
        m_pend[i] = 1'b1;
      end else if (i == cap) begin
        m_pend[i] = 1'b0;
      end
    end
    if (ovset) m_ovr = 1'b1; else if (ovr_clr) m_ovr = 1'b0;
    m_s2 = m_s1; m_s1 = btn_raw; m_cnt = (m_cnt + 1) % TD;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Monitor: level compares each cycle, scoreboard pop on every accepted event.
  initial forever begin
    @(negedge clk);
    #1;
    chk("btn_db", int'(btn_db), int'(m_db));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("evt_valid", int'(evt_valid), int'(m_busy));
    if (evt_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        chk("evt_id", int'(evt_id), exp_q[0].id);
        chk("evt_repeat", int'(evt_repeat), int'(exp_q[0].rep));
        if (evt_ready) begin
          got_id.push_back(int'(evt_id));
          got_rep.push_back(int'(evt_repeat));
          got_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic [NB-1:0] mask);
    btn_raw = mask;
    cycles(14);
    btn_raw = '0;
    cycles(24);
  endtask

  initial begin
    int n0, reps;
    cycles(3);
    chk("rst_btn_db", int'(btn_db), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_id", int'(evt_id), 0);
    chk("rst_evt_repeat", int'(evt_repeat), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    cycles(40);

    // Bounce on button 0, then a clean press
    n0 = got_id.size();
    for (int k = 0; k < 6; k++) begin btn_raw[0] = ~btn_raw[0]; cycles(4); end
    press(4'b0001);
    chk("bounce_event_count", got_id.size() - n0, 1);
    if (got_id.size() > n0) begin
      chk("bounce_id", got_id[n0], 0);
      chk("bounce_repeat", got_rep[n0], 0);
    end
    chk("bounce_overrun", int'(overrun), 0);

    // Round-robin from a fresh pointer
    rst = 1'b1; cycles(1); rst = 1'b0;
    n0 = got_id.size();
    press(4'b0101);
    chk("rr02_count", got_id.size() - n0, 2);
    if (got_id.size() >= n0 + 2) begin
      chk("rr02_first", got_id[n0], 0);
      chk("rr02_second", got_id[n0+1], 2);
      chk("rr02_gap", got_cyc[n0+1] - got_cyc[n0], 2);
    end
    n0 = got_id.size();
    press(4'b0011);
    chk("rr01_count", got_id.size() - n0, 2);
    if (got_id.size() >= n0 + 2) begin
      chk("rr01_first", got_id[n0], 0);
      chk("rr01_second", got_id[n0+1], 1);
    end

    // Backpressure and overrun
    evt_ready = 1'b0;
    n0 = got_id.size();
    press(4'b0010);
    chk("bp_offer_valid", int'(evt_valid), 1);
    chk("bp_offer_id", int'(evt_id), 1);
    press(4'b0010);
    chk("bp_second_no_overrun", int'(overrun), 0);
    press(4'b0010);
    chk("bp_third_overrun", int'(overrun), 1);
    evt_ready = 1'b1;
    cycles(10);
    chk("bp_delivered", got_id.size() - n0, 2);
    ovr_clr = 1'b1; cycles(1); ovr_clr = 1'b0; cycles(1);
    chk("ovr_clr", int'(overrun), 0);

    // Auto-repeat on a long hold of button 3
    n0 = got_id.size();
    btn_raw = 4'b1000;
    cycles(64);
    btn_raw = '0;
    cycles(40);
    reps = 0;
    for (int i = n0; i < got_id.size(); i++) reps += got_rep[i];
    chk("repeat_count_ge4", int'(reps >= 4), 1);
    if (got_id.size() >= n0 + 3) begin
      chk("repeat_press_first", got_rep[n0], 0);
      chk("repeat_first_delay", got_cyc[n0+1] - got_cyc[n0], HT * TD);
      chk("repeat_interval", got_cyc[n0+2] - got_cyc[n0+1], RT * TD);
    end

    // Reset while an event is offered and another is pending
    evt_ready = 1'b0;
    btn_raw = 4'b0011;
    cycles(20);
    chk("pre_rst_valid", int'(evt_valid), 1);
    btn_raw = '0;
    rst = 1'b1; cycles(1); rst = 1'b0;
    chk("post_rst_valid", int'(evt_valid), 0);
    chk("post_rst_btn_db", int'(btn_db), 0);
    chk("post_rst_overrun", int'(overrun), 0);
    n0 = got_id.size();
    evt_ready = 1'b1;
    cycles(60);
    chk("post_rst_no_event", got_id.size() - n0, 0);

    // Randomised traffic against the model
    for (int it = 0; it < 250; it++) begin
      btn_raw   = 4'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      ovr_clr   = ($urandom_range(0, 9) == 0);
      cycles($urandom_range(1, 30));
    end
    btn_raw = '0; evt_ready = 1'b1; ovr_clr = 1'b0;
    cycles(120);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_valid", int'(evt_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
